// File: rtl/mem_bus_arbiter.sv
// Round-robin two-port sequencer for the shared memory bus; one transaction at a time, m_en held WAIT_CYCLES+1 cycles.
// Ack pulses one cycle after the last access cycle (two cycles after grant on error); a losing port simply waits holding req.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_LIMIT  = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        rw0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic [31:0] rdata0,
  output logic        ack0,
  output logic        err0,
  input  logic        req1,
  input  logic        rw1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata1,
  output logic        ack1,
  output logic        err1,
  output logic        m_en,
  output logic        m_rw,
  output logic [31:0] abus,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [31:0] ADDR_MAX = 32'(ADDR_LIMIT - 4);
  localparam logic [3:0]  CNT_END  = 4'(WAIT_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        gnt_q, last_q, rw_q, err_pend_q;
  logic        m_en_q, m_rw_q;
  logic [31:0] abus_q, m_wdata_q;
  logic        ack0_q, ack1_q, err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;

  logic        gnt_d, sel_rw_d;
  logic [31:0] sel_addr_d, sel_wdata_d;

  // Contention goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    gnt_d       = (req0 && req1) ? ~last_q : req1;
    sel_rw_d    = gnt_d ? rw1    : rw0;
    sel_addr_d  = gnt_d ? addr1  : addr0;
    sel_wdata_d = gnt_d ? wdata1 : wdata0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      rw_q       <= 1'b1;
      err_pend_q <= 1'b0;
      m_en_q     <= 1'b0;
      m_rw_q     <= 1'b1;
      abus_q     <= '0;
      m_wdata_q  <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt_q  <= gnt_d;
            last_q <= gnt_d;
            rw_q   <= sel_rw_d;
            if (sel_addr_d > ADDR_MAX) begin
              err_pend_q <= 1'b1;
              state_q    <= DONE;
              if (gnt_d) rdata1_q <= '0;
              else       rdata0_q <= '0;
            end else begin
              err_pend_q <= 1'b0;
              state_q    <= ACCESS;
              cnt_q      <= '0;
              m_en_q     <= 1'b1;
              m_rw_q     <= sel_rw_d;
              abus_q     <= sel_addr_d;
              m_wdata_q  <= sel_rw_d ? 32'h0 : sel_wdata_d;
            end
          end
        end
        ACCESS: begin
          if (cnt_q != CNT_END) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            if (rw_q) begin
              if (gnt_q) rdata1_q <= m_rdata;
              else       rdata0_q <= m_rdata;
            end
            m_en_q    <= 1'b0;
            m_wdata_q <= '0;
            if (gnt_q) ack1_q <= 1'b1;
            else       ack0_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // Error path spends one extra DONE cycle so ack/err emerge registered from the pending flag.
          if (err_pend_q) begin
            err_pend_q <= 1'b0;
            if (gnt_q) begin
              ack1_q <= 1'b1;
              err1_q <= 1'b1;
            end else begin
              ack0_q <= 1'b1;
              err0_q <= 1'b1;
            end
          end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign m_en    = m_en_q;
  assign m_rw    = m_rw_q;
  assign abus    = abus_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-port arbiter and sequencer for the single CPU0 memory bus (abus, data, m_en, m_rw).
- Port 0 serves the CPU control unit; port 1 serves a secondary master (DMA/loader/debug).
- Grants one transaction at a time using round-robin and drives the memory enable/rw/address for a fixed number of cycles.
- Returns read data, and an error on out-of-range addresses, through a req/ack handshake.

Parameters:
- WAIT_CYCLES, 1, extra cycles m_en is held beyond the first access cycle (0..15).
- ADDR_LIMIT, 128, memory size in bytes; valid word addresses are 0..ADDR_LIMIT-4.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held high until ack0
- rw0  in  1  port 0 direction: 1=read, 0=write
- addr0  in  32  port 0 byte address
- wdata0  in  32  port 0 write data
- rdata0  out  32  port 0 read data, valid when ack0=1
- ack0  out  1  port 0 one-cycle completion pulse
- err0  out  1  port 0 error, valid with ack0
- req1, rw1, addr1, wdata1, rdata1, ack1, err1  same as port 0, for port 1
- m_en  out  1  memory enable
- m_rw  out  1  memory direction: 1=read, 0=write
- abus  out  32  memory address
- m_wdata  out  32  write data toward memory (top-level tristate drives dbus when m_en=1 and m_rw=0)
- m_rdata  in  32  read data from memory (dbus)

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; m_en=0, m_rw=1, abus=0, m_wdata=0; ack0/1=0, err0/1=0, rdata0/1=0; last_grant=1, so port 0 wins the first tie.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No req → stay in IDLE.
  - One req → grant that port.
  - Both req → grant the port != last_grant.
  - On grant: latch port id, rw, addr and wdata; set last_grant to the granted port.
  - If addr > ADDR_LIMIT-4 (unsigned) → go to DONE with err pending. m_en stays 0; rdata is set to 0.
  - Otherwise → go to ACCESS with cnt=0; m_en=1, m_rw=rw, abus=addr; m_wdata=wdata for writes, 0 for reads.
- ACCESS:
  - m_en, m_rw, abus and m_wdata are held stable.
  - If cnt < WAIT_CYCLES: cnt++, stay in ACCESS.
  - If cnt == WAIT_CYCLES: for reads, capture m_rdata into the granted port's rdata; go to DONE. On that edge m_en=0, abus holds, m_wdata=0.
- DONE:
  - ack of the granted port =1 for exactly this cycle; err =1 if an error is pending.
  - The other port's ack and err stay 0.
  - Next state is always IDLE, where ack and err return to 0.
- rdata of a port holds its last value until that port's next read completes, or until an error sets it to 0.
- Latency: req sampled at edge E → m_en high for WAIT_CYCLES+1 cycles starting after E → ack high in the cycle after edge E+WAIT_CYCLES+1.
  - Error path: ack is high in the cycle after E+1.
- Requester rules:
  - Keep req and its fields stable until ack.
  - Drop req at the edge that ends the ack cycle, unless it is issuing a new request.
  - Any req seen high in IDLE is treated as a new request.
- A requester dropping req during ACCESS does not abort the transaction; it completes and ack still pulses.
- A losing requester keeps waiting; with both ports continuously requesting, grants strictly alternate.
- Minimum issue spacing per transaction is WAIT_CYCLES+3 cycles (IDLE, ACCESS×(W+1), DONE).
- Reset asserted in any state: at that edge all registers take their reset values; m_en drops and no ack is issued for the aborted transaction.
- No memory write occurs after the reset edge.

Test Plan:
1. WAIT_CYCLES=1, port 0 read of addr 0x1C with memory word 0x00000001 → m_en high 2 cycles with abus=0x1C, m_rw=1; ack0 pulses 1 cycle, 3 cycles after the req sample edge; rdata0=0x00000001; err0=0; ack1 never high.
2. Port 1 write of 0xDEADBEEF to 0x20, then port 1 read of 0x20 → write cycles show m_rw=0, m_wdata=0xDEADBEEF; the read returns rdata1=0xDEADBEEF.
3. req0 and req1 asserted together at reset release and held continuously → grant order 0,1,0,1; each ack is single-cycle; no overlapping m_en periods.
4. Port 0 read of addr 0x7D (ADDR_LIMIT=128) → m_en never asserted; ack0 and err0 high together in the cycle after the edge following the sample; rdata0=0.
5. Reset asserted during the second ACCESS cycle of a port 1 write → next cycle m_en=0, ack1=0, state IDLE; then a simultaneous req0/req1 grants port 0 first.
6. WAIT_CYCLES=0, back-to-back port 0 reads → m_en high 1 cycle per access; acks spaced exactly 3 cycles apart.
